mem_port_arbiter: RTL and testbench

Shares one single-port instruction/data memory between the RISC-V fetch path and the load/store path (lw/sw, MemRW). It grants one requester at a time using round-robin arbitration and drives a valid/ready memory handshake. A watchdog aborts accesses the memory never acknowledges. It sits between the core's PC/fetch logic, the datapath's memory stage, and the memory model.

---
 rtl/riscv_mem_pkg.sv | 17 +
 rtl/mem_arb_watchdog.sv | 34 +++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
//   Shared types and constants for the fetch/data memory port arbiter:
//   FSM state encoding, requester ids and the default watchdog limit.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog
//   Saturating cycle counter used to abort memory accesses that are never
//   acknowledged.
//   Ports:
//     clk, rst_n  clock, async active-low reset
//     clr         zero the count (access start)
//     en          count this cycle (waiting on memory)
//     expired     count has reached TIMEOUT
module mem_arb_watchdog
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT));

  // Saturates at TIMEOUT so a stalled FSM can never see the count wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && !expired)   cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter sharing one single-port memory between the fetch
//   path (if_*) and the load/store path (d_*). One access in flight at a
//   time: IDLE -> BUSY (mem_valid high until mem_ready or watchdog abort)
//   -> RESP (one-cycle ready pulse to the granted requester) -> IDLE.
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     if_req/if_addr             fetch request, held until if_ready
//     if_ready/if_rdata          fetch completion pulse and data
//     d_req/d_we/d_addr/d_wdata  load/store request, held until d_ready
//     d_ready/d_rdata            data completion pulse and load data
//     err                        qualifies a ready pulse as a watchdog abort
//     mem_valid/mem_we/mem_addr/mem_wdata  memory request (registered)
//     mem_ready/mem_rdata        memory acknowledge and read data
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t    state;
  logic          gnt_id;
  logic          last_gnt;
  logic          any_req;
  logic          gnt_sel;
  logic          wd_clr;
  logic          wd_en;
  logic          wd_expired;
  logic [DW-1:0] resp_data;

  assign any_req = if_req | d_req;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt_sel = PORT_IF;
    if (if_req && d_req) gnt_sel = ~last_gnt;
    else if (d_req)      gnt_sel = PORT_D;
  end

  assign wd_clr    = (state == IDLE) && any_req;
  assign wd_en     = (state == BUSY) && !mem_ready;
  // Aborted accesses return zero data.
  assign resp_data = mem_ready ? mem_rdata : '0;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_id    <= PORT_IF;
      last_gnt  <= PORT_D;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id    <= gnt_sel;
            last_gnt  <= gnt_sel;
            mem_valid <= 1'b1;
            if (gnt_sel == PORT_IF) begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end else begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end
            state <= BUSY;
          end
        end
        BUSY: begin
          // mem_ready takes priority over an expiring watchdog.
          if (mem_ready || wd_expired) begin
            mem_valid <= 1'b0;
            err       <= !mem_ready;
            if (gnt_id == PORT_IF) begin
              if_ready <= 1'b1;
              if_rdata <= resp_data;
            end else begin
              d_ready  <= 1'b1;
              d_rdata  <= resp_data;
            end
            state <= RESP;
          end
        end
        RESP: begin
          // Requests are not looked at here, so a still-high req from the
          // requester being answered is not granted a second time.
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
          err      <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (TIMEOUT=4). Inputs are driven 1ns
//   after the rising edge, outputs are checked at the same point.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int vecs;
  int errs;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .err(err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; mem_ready = 0; mem_rdata = 0;
    #3;
    vecs++; if ({mem_valid, mem_we, mem_addr, mem_wdata} !== 66'h0) begin errs++; $display("FAIL reset_mem got v=%0b we=%0b a=%h wd=%h want all 0", mem_valid, mem_we, mem_addr, mem_wdata); end
    vecs++; if ({if_ready, d_ready, err, if_rdata, d_rdata} !== 67'h0) begin errs++; $display("FAIL reset_resp got ir=%0b dr=%0b e=%0b ird=%h drd=%h want all 0", if_ready, d_ready, err, if_rdata, d_rdata); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    // stray mem_ready in IDLE is ignored
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 0;
    vecs++; if ({mem_valid, if_ready, d_ready} !== 3'b000) begin errs++; $display("FAIL idle_ready_ignored got v=%0b ir=%0b dr=%0b want 000", mem_valid, if_ready, d_ready); end
    if_req = 1; if_addr = 32'h100;
    tick();
    vecs++; if ({mem_valid, mem_we, mem_addr, mem_wdata, if_ready} !== {1'b1, 1'b0, 32'h100, 32'h0, 1'b0}) begin errs++; $display("FAIL fetch_issue got v=%0b we=%0b a=%h wd=%h ir=%0b want 1 0 100 0 0", mem_valid, mem_we, mem_addr, mem_wdata, if_ready); end
    mem_ready = 1; mem_rdata = 32'h0050_0093;
    tick();
    mem_ready = 0; if_req = 0;
    vecs++; if ({if_ready, if_rdata, err, d_ready, mem_valid} !== {1'b1, 32'h0050_0093, 1'b0, 1'b0, 1'b0}) begin errs++; $display("FAIL fetch_resp got ir=%0b rd=%h e=%0b dr=%0b v=%0b want 1 00500093 0 0 0", if_ready, if_rdata, err, d_ready, mem_valid); end
    tick();
    vecs++; if ({if_ready, mem_valid} !== 2'b00) begin errs++; $display("FAIL fetch_pulse_len got ir=%0b v=%0b want 00", if_ready, mem_valid); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr;
    do_reset();
    if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 0) ? 32'h200 : 32'h3000;
      tick();
      vecs++; if ({mem_valid, mem_addr} !== {1'b1, exp_addr}) begin errs++; $display("FAIL rr_grant%0d got v=%0b a=%h want 1 %h", i, mem_valid, mem_addr, exp_addr); end
      mem_ready = 1; mem_rdata = 32'h1000 + i;
      tick();
      mem_ready = 0;
      if (i % 2 == 0) begin
        vecs++; if ({if_ready, d_ready, if_rdata} !== {1'b1, 1'b0, 32'h1000 + i}) begin errs++; $display("FAIL rr_resp%0d got ir=%0b dr=%0b rd=%h want 1 0 %h", i, if_ready, d_ready, if_rdata, 32'h1000 + i); end
      end else begin
        vecs++; if ({if_ready, d_ready, d_rdata} !== {1'b0, 1'b1, 32'h1000 + i}) begin errs++; $display("FAIL rr_resp%0d got ir=%0b dr=%0b rd=%h want 0 1 %h", i, if_ready, d_ready, d_rdata, 32'h1000 + i); end
      end
      tick();
      vecs++; if ({mem_valid, if_ready, d_ready} !== 3'b000) begin errs++; $display("FAIL rr_resp_mask%0d got v=%0b ir=%0b dr=%0b want 000", i, mem_valid, if_ready, d_ready); end
    end
    if_req = 0; d_req = 0;
    tick();
  endtask

  task automatic test_store();
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    tick();
    if_req = 1; if_addr = 32'h400;
    for (int j = 0; j < 3; j++) begin
      vecs++; if ({mem_valid, mem_we, mem_addr, mem_wdata, d_ready, if_ready} !== {1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin errs++; $display("FAIL store_hold%0d got v=%0b we=%0b a=%h wd=%h dr=%0b ir=%0b", j, mem_valid, mem_we, mem_addr, mem_wdata, d_ready, if_ready); end
      tick();
    end
    mem_ready = 1; mem_rdata = 32'h55;
    tick();
    mem_ready = 0; d_req = 0;
    vecs++; if ({d_ready, if_ready, err, mem_valid, d_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h55}) begin errs++; $display("FAIL store_resp got dr=%0b ir=%0b e=%0b v=%0b rd=%h want 1 0 0 0 55", d_ready, if_ready, err, mem_valid, d_rdata); end
    tick();
    tick();
    vecs++; if ({mem_valid, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h400, 32'h0}) begin errs++; $display("FAIL store_waiter_fetch got v=%0b we=%0b a=%h wd=%h want 1 0 400 0", mem_valid, mem_we, mem_addr, mem_wdata); end
    mem_ready = 1; mem_rdata = 32'hABCD;
    tick();
    mem_ready = 0; if_req = 0;
    vecs++; if ({if_ready, if_rdata} !== {1'b1, 32'hABCD}) begin errs++; $display("FAIL store_waiter_resp got ir=%0b rd=%h want 1 abcd", if_ready, if_rdata); end
    tick();
  endtask

  task automatic test_timeout();
    d_req = 1; d_we = 0; d_addr = 32'h3004;
    tick();  // mem_valid rises here
    vecs++; if (mem_valid !== 1'b1) begin errs++; $display("FAIL to_valid got %0b want 1", mem_valid); end
    for (int j = 1; j <= 4; j++) begin
      tick();
      vecs++; if ({mem_valid, d_ready} !== 2'b10) begin errs++; $display("FAIL to_wait%0d got v=%0b dr=%0b want 1 0", j, mem_valid, d_ready); end
    end
    tick();  // 5 cycles after mem_valid rose
    d_req = 0;
    vecs++; if ({mem_valid, d_ready, err, d_rdata} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin errs++; $display("FAIL to_abort got v=%0b dr=%0b e=%0b rd=%h want 0 1 1 0", mem_valid, d_ready, err, d_rdata); end
    tick();
    vecs++; if ({d_ready, err} !== 2'b00) begin errs++; $display("FAIL to_pulse_len got dr=%0b e=%0b want 00", d_ready, err); end
    // boundary: acknowledge on the 4th BUSY cycle
    d_req = 1; d_addr = 32'h3008;
    tick();
    tick(); tick(); tick();
    mem_ready = 1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_ready = 0; d_req = 0;
    vecs++; if ({d_ready, err, d_rdata} !== {1'b1, 1'b0, 32'hCAFE_0001}) begin errs++; $display("FAIL to_boundary got dr=%0b e=%0b rd=%h want 1 0 cafe0001", d_ready, err, d_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_we = 0; d_addr = 32'h500;
    tick();
    if_req = 1; if_addr = 32'h600;
    vecs++; if (mem_valid !== 1'b1) begin errs++; $display("FAIL rst_mid_valid got %0b want 1", mem_valid); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (mem_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_async got v=%0b want 0", mem_valid); end
    mem_ready = 1;
    tick();
    mem_ready = 0;
    vecs++; if ({if_ready, d_ready, err} !== 3'b000) begin errs++; $display("FAIL rst_mid_nopulse got ir=%0b dr=%0b e=%0b want 000", if_ready, d_ready, err); end
    rst_n = 1'b1;
    tick();
    vecs++; if ({mem_valid, mem_addr} !== {1'b1, 32'h600}) begin errs++; $display("FAIL rst_mid_fetch_first got v=%0b a=%h want 1 600", mem_valid, mem_addr); end
    mem_ready = 1; mem_rdata = 32'h77;
    tick();
    mem_ready = 0; if_req = 0;
    vecs++; if ({if_ready, if_rdata} !== {1'b1, 32'h77}) begin errs++; $display("FAIL rst_mid_fetch_resp got ir=%0b rd=%h want 1 77", if_ready, if_rdata); end
    tick();
    tick();
    vecs++; if ({mem_valid, mem_addr} !== {1'b1, 32'h500}) begin errs++; $display("FAIL rst_mid_data got v=%0b a=%h want 1 500", mem_valid, mem_addr); end
    mem_ready = 1; mem_rdata = 32'h88;
    tick();
    mem_ready = 0; d_req = 0;
    vecs++; if ({d_ready, d_rdata} !== {1'b1, 32'h88}) begin errs++; $display("FAIL rst_mid_data_resp got dr=%0b rd=%h want 1 88", d_ready, d_rdata); end
    tick();
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_fetch();
    test_round_robin();
    test_store();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
